// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared types and constants for the marker locator.
//   state_t              : frame tracking FSM states (SYNC, ACCUM, REPORT)
//   CAM_IMG_W/CAM_IMG_H  : default frame geometry (640x480)
//   X_W/Y_W/POS_W/CNT_W  : column, row, linear position and hit-count widths
// -----------------------------------------------------------------------------
package cam_pkg;

    localparam int unsigned CAM_IMG_W = 640;
    localparam int unsigned CAM_IMG_H = 480;

    localparam int unsigned X_W   = 10;
    localparam int unsigned Y_W   = 9;
    localparam int unsigned POS_W = 20;
    localparam int unsigned CNT_W = 19;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/bbox_accum.sv
// -----------------------------------------------------------------------------
// bbox_accum
// Running bounding box and saturating hit counter for one frame.
// Ports:
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_clear             : start of a new frame; forget everything seen so far
//   i_hit, i_x, i_y     : an accepted hit at column i_x, row i_y
//   o_x_min .. o_y_max  : running box (all zero while no hit has been seen)
//   o_count             : running hit count, saturating at all-ones
// -----------------------------------------------------------------------------
module bbox_accum
    import cam_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_hit,
    input  logic [X_W-1:0]   i_x,
    input  logic [Y_W-1:0]   i_y,
    output logic [X_W-1:0]   o_x_min,
    output logic [X_W-1:0]   o_x_max,
    output logic [Y_W-1:0]   o_y_min,
    output logic [Y_W-1:0]   o_y_max,
    output logic [CNT_W-1:0] o_count
);

    logic [X_W-1:0]   r_x_min, r_x_max;
    logic [Y_W-1:0]   r_y_min, r_y_max;
    logic [CNT_W-1:0] r_count;
    logic             w_first;

    // A hit on the clearing cycle, or the first hit after a clear, seeds the box.
    // A saturated counter is never zero, so it cannot be mistaken for "no hits".
    assign w_first = i_clear || (r_count == '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_x_min <= '0;
            r_x_max <= '0;
            r_y_min <= '0;
            r_y_max <= '0;
            r_count <= '0;
        end else if (i_hit && w_first) begin
            r_x_min <= i_x;
            r_x_max <= i_x;
            r_y_min <= i_y;
            r_y_max <= i_y;
            r_count <= CNT_W'(1);
        end else if (i_hit) begin
            if (i_x < r_x_min) r_x_min <= i_x;
            if (i_x > r_x_max) r_x_max <= i_x;
            if (i_y < r_y_min) r_y_min <= i_y;
            if (i_y > r_y_max) r_y_max <= i_y;
            if (r_count != '1) r_count <= r_count + 1'b1;
        end else if (i_clear) begin
            r_x_min <= '0;
            r_x_max <= '0;
            r_y_min <= '0;
            r_y_max <= '0;
            r_count <= '0;
        end
    end

    assign o_x_min = r_x_min;
    assign o_x_max = r_x_max;
    assign o_y_min = r_y_min;
    assign o_y_max = r_y_max;
    assign o_count = r_count;

endmodule

// File: rtl/marker_locator.sv
// -----------------------------------------------------------------------------
// marker_locator
// Tracks a raster pixel stream, finds pixels equal to MARK_VAL and reports the
// bounding box and hit count of each complete, gap-consistent frame.
// Ports:
//   pclk, reset                 : clock, synchronous active-high reset
//   pix_valid/pix_pos/pix_data  : pixel stream (linear index + value)
//   x_min/x_max/y_min/y_max     : bounding box of the last reported frame
//   hit_count, found            : hits of last reported frame, found >= MIN_HITS
//   box_valid                   : one-cycle pulse when the outputs update
// Build option:
//   MARKER_LOCATOR_RUN_FILTER_EN : a mark counts only once it is at least the
//                                  RUN_LEN-th consecutive mark in its row.
// -----------------------------------------------------------------------------
module marker_locator
    import cam_pkg::*;
#(
    parameter int unsigned IMG_W    = CAM_IMG_W,
    parameter int unsigned IMG_H    = CAM_IMG_H,
    parameter logic [7:0]  MARK_VAL = 8'd255,
    parameter int unsigned MIN_HITS = 16,
    parameter int unsigned RUN_LEN  = 5
)(
    input  logic             pclk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic [POS_W-1:0] pix_pos,
    input  logic [7:0]       pix_data,
    output logic [X_W-1:0]   x_min,
    output logic [X_W-1:0]   x_max,
    output logic [Y_W-1:0]   y_min,
    output logic [Y_W-1:0]   y_max,
    output logic [CNT_W-1:0] hit_count,
    output logic             found,
    output logic             box_valid
);

    state_t           r_state, w_next_state;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [POS_W-1:0] w_exp_pos;
    logic             w_accept, w_mark, w_hit, w_clear;
    logic             w_last_col, w_last_row, w_last;
    logic             w_report;

    logic [X_W-1:0]   w_acc_x_min, w_acc_x_max;
    logic [Y_W-1:0]   w_acc_y_min, w_acc_y_max;
    logic [CNT_W-1:0] w_acc_count;

    logic [X_W-1:0]   r_x_min, r_x_max;
    logic [Y_W-1:0]   r_y_min, r_y_max;
    logic [CNT_W-1:0] r_hit_count;
    logic             r_found;

    assign w_exp_pos  = POS_W'(r_y) * POS_W'(IMG_W) + POS_W'(r_x);
    assign w_last_col = (r_x == X_W'(IMG_W - 1));
    assign w_last_row = (r_y == Y_W'(IMG_H - 1));
    assign w_last     = w_last_col && w_last_row;
    assign w_mark     = (pix_data == MARK_VAL);
    assign w_clear    = (r_state == ST_SYNC) && w_accept;

    // Next state; w_accept marks a pixel that belongs to the current frame.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (pix_valid && (pix_pos == '0)) begin
                    w_accept     = 1'b1;
                    w_next_state = w_last ? ST_REPORT : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (pix_valid) begin
                    if (pix_pos == w_exp_pos) begin
                        w_accept     = 1'b1;
                        w_next_state = w_last ? ST_REPORT : ST_ACCUM;
                    end else begin
                        w_next_state = ST_SYNC;
                    end
                end
            end
            ST_REPORT: w_next_state = ST_SYNC;
            default:   w_next_state = ST_SYNC;
        endcase
    end

    // State and raster position; position returns to 0,0 whenever we fall back
    // to SYNC so a new frame always starts from the origin.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state <= ST_SYNC;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                if (w_last_col) begin
                    r_x <= '0;
                    r_y <= w_last_row ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end else if (w_next_state == ST_SYNC) begin
                r_x <= '0;
                r_y <= '0;
            end
        end
    end

`ifdef MARKER_LOCATOR_RUN_FILTER_EN
    logic [15:0] r_run;
    logic [15:0] w_run_inc;

    assign w_run_inc = r_run + 16'd1;
    assign w_hit     = w_accept && w_mark && ({16'd0, w_run_inc} >= RUN_LEN);

    // Run length of consecutive marks in the current row, held once it reaches
    // RUN_LEN so it cannot overflow on long runs.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_run <= '0;
        end else if (w_accept) begin
            if (!w_mark || w_last_col)
                r_run <= '0;
            else if ({16'd0, r_run} < RUN_LEN)
                r_run <= w_run_inc;
        end else if (w_next_state == ST_SYNC) begin
            r_run <= '0;
        end
    end
`else
    // RUN_LEN only matters with the run filter built in.
    logic w_unused_run_len;
    assign w_unused_run_len = (RUN_LEN != 0);
    assign w_hit            = w_accept && w_mark;
`endif

    bbox_accum u_bbox_accum (
        .i_clk   (pclk),
        .i_reset (reset),
        .i_clear (w_clear),
        .i_hit   (w_hit),
        .i_x     (r_x),
        .i_y     (r_y),
        .o_x_min (w_acc_x_min),
        .o_x_max (w_acc_x_max),
        .o_y_min (w_acc_y_min),
        .o_y_max (w_acc_y_max),
        .o_count (w_acc_count)
    );

    // Output holding registers, loaded during the single REPORT cycle.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_x_min     <= '0;
            r_x_max     <= '0;
            r_y_min     <= '0;
            r_y_max     <= '0;
            r_hit_count <= '0;
            r_found     <= 1'b0;
        end else if (r_state == ST_REPORT) begin
            r_x_min     <= w_acc_x_min;
            r_x_max     <= w_acc_x_max;
            r_y_min     <= w_acc_y_min;
            r_y_max     <= w_acc_y_max;
            r_hit_count <= w_acc_count;
            r_found     <= (w_acc_count >= CNT_W'(MIN_HITS));
        end
    end

    // During REPORT the fresh values are forwarded straight from the
    // accumulator, so box_valid appears one cycle after the last pixel with the
    // matching data; reset suppresses the pulse.
    assign w_report  = (r_state == ST_REPORT) && !reset;
    assign box_valid = w_report;
    assign x_min     = w_report ? w_acc_x_min : r_x_min;
    assign x_max     = w_report ? w_acc_x_max : r_x_max;
    assign y_min     = w_report ? w_acc_y_min : r_y_min;
    assign y_max     = w_report ? w_acc_y_max : r_y_max;
    assign hit_count = w_report ? w_acc_count : r_hit_count;
    assign found     = w_report ? (w_acc_count >= CNT_W'(MIN_HITS)) : r_found;

endmodule

// File: tb/tb_marker_locator.sv
// -----------------------------------------------------------------------------
// tb_marker_locator
// Scoreboard bench for marker_locator on a reduced 40x30 frame. Each frame is
// built as a pixel array, its expected report is computed from the array, and
// a monitor compares every box_valid pulse against the queued expectation.
// Honours MARKER_LOCATOR_RUN_FILTER_EN in the reference model.
// -----------------------------------------------------------------------------
module tb_marker_locator;

    localparam int W    = 40;
    localparam int H    = 30;
    localparam int N    = W * H;
    localparam int MINH = 16;
    localparam int RUNL = 5;
    localparam logic [7:0] MARK = 8'd255;

    logic        pclk = 1'b0;
    logic        reset;
    logic        pix_valid;
    logic [19:0] pix_pos;
    logic [7:0]  pix_data;
    logic [9:0]  x_min, x_max;
    logic [8:0]  y_min, y_max;
    logic [18:0] hit_count;
    logic        found;
    logic        box_valid;

    marker_locator #(
        .IMG_W    (W),
        .IMG_H    (H),
        .MARK_VAL (MARK),
        .MIN_HITS (MINH),
        .RUN_LEN  (RUNL)
    ) dut (
        .pclk      (pclk),
        .reset     (reset),
        .pix_valid (pix_valid),
        .pix_pos   (pix_pos),
        .pix_data  (pix_data),
        .x_min     (x_min),
        .x_max     (x_max),
        .y_min     (y_min),
        .y_max     (y_max),
        .hit_count (hit_count),
        .found     (found),
        .box_valid (box_valid)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int xmin; int xmax; int ymin; int ymax; int cnt; int found; int cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       last_rep;
    exp_t       zero_rep;
    exp_t       mon_e;
    logic [7:0] frm [N];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic chk_outputs(input string tag, input exp_t e);
        chk({tag, "_x_min"},     int'(x_min),     e.xmin);
        chk({tag, "_x_max"},     int'(x_max),     e.xmax);
        chk({tag, "_y_min"},     int'(y_min),     e.ymin);
        chk({tag, "_y_max"},     int'(y_max),     e.ymax);
        chk({tag, "_hit_count"}, int'(hit_count), e.cnt);
        chk({tag, "_found"},     int'(found),     e.found);
    endtask

    // Reference: scan the frame, apply the hit rule, take min/max of hit coords.
    function automatic exp_t model();
        exp_t e;
        int   run;
        bit   hit;
        e   = '{default: 0};
        run = 0;
        for (int i = 0; i < N; i++) begin
            int x = i % W;
            int y = i / W;
            if (x == 0) run = 0;
            run = (frm[i] == MARK) ? run + 1 : 0;
`ifdef MARKER_LOCATOR_RUN_FILTER_EN
            hit = (frm[i] == MARK) && (run >= RUNL);
`else
            hit = (frm[i] == MARK);
`endif
            if (hit) begin
                if (e.cnt == 0) begin
                    e.xmin = x; e.xmax = x; e.ymin = y; e.ymax = y;
                end else begin
                    if (x < e.xmin) e.xmin = x;
                    if (x > e.xmax) e.xmax = x;
                    if (y < e.ymin) e.ymin = y;
                    if (y > e.ymax) e.ymax = y;
                end
                e.cnt++;
            end
        end
        e.found = (e.cnt >= MINH) ? 1 : 0;
        return e;
    endfunction

    task automatic fill_bg();
        for (int i = 0; i < N; i++) frm[i] = 8'($urandom_range(254));
    endtask

    task automatic put(input int x, input int y);
        frm[y * W + x] = MARK;
    endtask

    task automatic fill_rand(input int pct);
        fill_bg();
        for (int i = 0; i < N; i++)
            if ($urandom_range(99) < pct) frm[i] = MARK;
    endtask

    task automatic do_reset();
        @(negedge pclk);
        reset     = 1'b1;
        pix_valid = 1'b0;
        @(negedge pclk);
        chk_outputs("reset", zero_rep);
        chk("reset_box_valid", int'(box_valid), 0);
        reset    = 1'b0;
        last_rep = zero_rep;
    endtask

    // Drive the current frame. skip_pos drops one index, rst_pos resets the DUT
    // at that index; either of those means the frame must not be reported.
    task automatic drive_frame(input int gap_pct, input int skip_pos, input int rst_pos);
        exp_t e;
        bit   full;
        full = (skip_pos < 0) && (rst_pos < 0);
        e    = model();
        for (int i = 0; i < N; i++) begin
            if (i == rst_pos) begin
                do_reset();
                return;
            end
            for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
                @(negedge pclk);
                pix_valid = 1'b0;
            end
            @(negedge pclk);
            if (i == N / 4) chk_outputs("hold", last_rep);
            if (i == skip_pos) begin
                pix_valid = 1'b0;
                continue;
            end
            pix_valid = 1'b1;
            pix_pos   = 20'(i);
            pix_data  = frm[i];
            if (i == N - 1 && full) begin
                e.cyc    = cyc + 1;
                exp_q.push_back(e);
                last_rep = e;
            end
        end
        @(negedge pclk);
        pix_valid = 1'b0;
    endtask

    // Monitor: every box_valid pulse must match the oldest queued expectation.
    always @(negedge pclk) begin
        if (box_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_box_valid: got box_valid=1 at cycle %0d expected no report", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk_outputs("report", mon_e);
                chk("report_latency", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion by cycle %0d expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        zero_rep  = '{default: 0};
        last_rep  = zero_rep;
        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_pos   = '0;
        pix_data  = '0;
        repeat (3) @(negedge pclk);
        chk_outputs("por", zero_rep);
        chk("por_box_valid", int'(box_valid), 0);
        reset = 1'b0;

        // Frame without any mark
        fill_bg();
        drive_frame(0, -1, -1);

        // Single mark
        fill_bg();
        put(10, 5);
        drive_frame(0, -1, -1);

        // 20x20 block
        fill_bg();
        for (int y = 5; y < 25; y++)
            for (int x = 12; x < 32; x++) put(x, y);
        drive_frame(0, -1, -1);

        // Marks on the very first and very last pixel
        fill_bg();
        put(0, 0);
        put(W - 1, H - 1);
        drive_frame(0, -1, -1);

        // Lost pixel: index 1000 skipped, then a clean frame
        fill_rand(5);
        drive_frame(0, 1000, -1);
        fill_rand(5);
        drive_frame(10, -1, -1);

        // Reset mid-frame, then a fresh frame
        fill_rand(5);
        drive_frame(0, -1, 600);
        fill_rand(5);
        drive_frame(0, -1, -1);

        // Row runs of 4 and 7 marks
        fill_bg();
        for (int x = 2; x < 6; x++)   put(x, 3);
        for (int x = 10; x < 17; x++) put(x, 3);
        drive_frame(0, -1, -1);

        // Same random frame without and with gaps
        fill_rand(30);
        drive_frame(0, -1, -1);
        drive_frame(40, -1, -1);

        // Dense random frames, runs crossing row ends
        for (int k = 0; k < 3; k++) begin
            fill_rand(60);
            drive_frame(20, -1, -1);
        end

        repeat (5) @(negedge pclk);
        chk("pending_reports", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
